// File: rtl/core_seq_pkg.sv
// Shared definitions for the core run sequencer.
// Contents:
//   seq_state_e      - sequencer FSM state encoding
//   STATUS_*         - completion status codes reported in done_status
//   STATUS_BITS      - width of the status field
//   PHASE_TIMER_BITS - width of the phase duration down-counter
//   phase_load()     - converts a phase length in cycles into a timer load value
package core_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StResetHold,
        StStart,
        StRun,
        StReport,
        StDone
    } seq_state_e;

    localparam int unsigned STATUS_BITS = 2;

    localparam logic [STATUS_BITS-1:0] STATUS_HALT    = 2'd0;
    localparam logic [STATUS_BITS-1:0] STATUS_TIMEOUT = 2'd1;
    localparam logic [STATUS_BITS-1:0] STATUS_ABORT   = 2'd2;

    localparam int unsigned PHASE_TIMER_BITS = 32;

    // The timer counts down to zero and the phase ends in the cycle it reads
    // zero, so a phase of N cycles is loaded with N-1.
    function automatic logic [PHASE_TIMER_BITS-1:0] phase_load(input int unsigned cycles);
        if (cycles == 0) begin
            return '0;
        end
        return PHASE_TIMER_BITS'(cycles - 1);
    endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// Loadable down-counter timing the fixed-length phases of the run sequencer.
// Ports:
//   clock         - clock
//   reset         - synchronous active-low reset
//   load_i        - load load_value_i this cycle (takes priority over counting)
//   load_value_i  - value to load
//   zero_o        - counter currently reads zero
// The counter decrements once per cycle and stops at zero.
module seq_phase_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/core_run_sequencer.sv
// Run controller for a single RISC_V_Core instance.
// Accepts a run request (program address, cycle budget) from the host, walks the
// core through reset hold, start, run and report phases, then returns a completion
// record (RUN cycles counted, termination status).
// Ports:
//   clock, reset                       - clock, synchronous active-low reset
//   host_req_valid / host_req_ready    - run request handshake
//   host_prog_address                  - program start address
//   host_cycle_budget                  - max RUN cycles, 0 = unlimited
//   host_abort                         - level, terminate current run
//   core_halted                        - core reports program end
//   core_reset, core_start,
//   core_prog_address, core_report     - core control (core_reset active-high)
//   done_valid / done_ready            - completion record handshake
//   done_cycles, done_status           - completion record
module core_run_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS  = 20,
    parameter int unsigned CYCLE_BITS    = 32,
    parameter int unsigned RESET_CYCLES  = 4,
    parameter int unsigned START_CYCLES  = 5,
    parameter int unsigned REPORT_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    host_req_valid,
    output logic                    host_req_ready,
    input  logic [ADDRESS_BITS-1:0] host_prog_address,
    input  logic [CYCLE_BITS-1:0]   host_cycle_budget,
    input  logic                    host_abort,
    input  logic                    core_halted,
    output logic                    core_reset,
    output logic                    core_start,
    output logic [ADDRESS_BITS-1:0] core_prog_address,
    output logic                    core_report,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [CYCLE_BITS-1:0]   done_cycles,
    output logic [STATUS_BITS-1:0]  done_status
);

    seq_state_e                  state_q;
    logic [CYCLE_BITS-1:0]       budget_q;
    logic [CYCLE_BITS-1:0]       done_cycles_q;
    logic [STATUS_BITS-1:0]      done_status_q;
    logic [ADDRESS_BITS-1:0]     core_prog_address_q;
    logic                        core_reset_q;
    logic                        core_start_q;
    logic                        core_report_q;
    logic                        done_valid_q;

    logic [CYCLE_BITS-1:0]       cycles_inc;
    logic                        run_timeout;
    logic                        run_exit;
    logic [STATUS_BITS-1:0]      run_status;
    logic                        timer_load;
    logic [PHASE_TIMER_BITS-1:0] timer_value;
    logic                        timer_zero;

    // RUN-phase bookkeeping: saturating count and exit decision for this cycle.
    always_comb begin
        cycles_inc  = (done_cycles_q == '1) ? done_cycles_q : done_cycles_q + CYCLE_BITS'(1);
        run_timeout = (budget_q != '0) && (cycles_inc == budget_q);
        run_exit    = core_halted | run_timeout | host_abort;
        if (core_halted) begin
            run_status = STATUS_HALT;
        end else if (run_timeout) begin
            run_status = STATUS_TIMEOUT;
        end else begin
            run_status = STATUS_ABORT;
        end
    end

    // Timer is loaded on entry to every timed phase; mirrors the transitions below.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        unique case (state_q)
            StIdle: begin
                if (host_req_valid) begin
                    timer_load  = 1'b1;
                    timer_value = phase_load(RESET_CYCLES);
                end
            end
            StResetHold: begin
                if (host_abort) begin
                    timer_load  = 1'b1;
                    timer_value = phase_load(REPORT_CYCLES);
                end else if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = phase_load(START_CYCLES);
                end
            end
            StStart: begin
                if (host_abort) begin
                    timer_load  = 1'b1;
                    timer_value = phase_load(REPORT_CYCLES);
                end
            end
            StRun: begin
                if (run_exit) begin
                    timer_load  = 1'b1;
                    timer_value = phase_load(REPORT_CYCLES);
                end
            end
            default: begin
                timer_load  = 1'b0;
                timer_value = '0;
            end
        endcase
    end

    seq_phase_timer #(
        .WIDTH (PHASE_TIMER_BITS)
    ) u_phase_timer (
        .clock        (clock),
        .reset        (reset),
        .load_i       (timer_load),
        .load_value_i (timer_value),
        .zero_o       (timer_zero)
    );

    // Main FSM; all core/host outputs are registered alongside the state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q             <= StIdle;
            budget_q            <= '0;
            done_cycles_q       <= '0;
            done_status_q       <= STATUS_HALT;
            core_prog_address_q <= '0;
            core_reset_q        <= 1'b1;
            core_start_q        <= 1'b0;
            core_report_q       <= 1'b0;
            done_valid_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (host_req_valid) begin
                        state_q             <= StResetHold;
                        budget_q            <= host_cycle_budget;
                        core_prog_address_q <= host_prog_address;
                        done_cycles_q       <= '0;
                        core_reset_q        <= 1'b1;
                    end
                end
                StResetHold: begin
                    if (host_abort) begin
                        state_q       <= StReport;
                        done_status_q <= STATUS_ABORT;
                        core_reset_q  <= 1'b0;
                        core_report_q <= 1'b1;
                    end else if (timer_zero) begin
                        state_q      <= StStart;
                        core_reset_q <= 1'b0;
                        core_start_q <= 1'b1;
                    end
                end
                StStart: begin
                    if (host_abort) begin
                        state_q       <= StReport;
                        done_status_q <= STATUS_ABORT;
                        core_start_q  <= 1'b0;
                        core_report_q <= 1'b1;
                    end else if (timer_zero) begin
                        state_q      <= StRun;
                        core_start_q <= 1'b0;
                    end
                end
                StRun: begin
                    done_cycles_q <= cycles_inc;
                    if (run_exit) begin
                        state_q       <= StReport;
                        done_status_q <= run_status;
                        core_report_q <= 1'b1;
                    end
                end
                StReport: begin
                    if (timer_zero) begin
                        state_q       <= StDone;
                        core_report_q <= 1'b0;
                        done_valid_q  <= 1'b1;
                    end
                end
                StDone: begin
                    if (done_ready) begin
                        state_q      <= StIdle;
                        done_valid_q <= 1'b0;
                        core_reset_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign host_req_ready    = (state_q == StIdle);
    assign core_reset        = core_reset_q;
    assign core_start        = core_start_q;
    assign core_report       = core_report_q;
    assign core_prog_address = core_prog_address_q;
    assign done_valid        = done_valid_q;
    assign done_cycles       = done_cycles_q;
    assign done_status       = done_status_q;

endmodule

// File: tb/tb_core_run_sequencer.sv
module tb_core_run_sequencer;

    localparam int AB  = 20;
    localparam int CB  = 32;
    localparam int R   = 4;
    localparam int S   = 5;
    localparam int REP = 1;

    localparam logic [1:0] ST_HALT    = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_ABORT   = 2'd2;

    logic          clock = 1'b0;
    logic          reset;
    logic          host_req_valid;
    logic          host_req_ready;
    logic [AB-1:0] host_prog_address;
    logic [CB-1:0] host_cycle_budget;
    logic          host_abort;
    logic          core_halted;
    logic          core_reset;
    logic          core_start;
    logic [AB-1:0] core_prog_address;
    logic          core_report;
    logic          done_valid;
    logic          done_ready;
    logic [CB-1:0] done_cycles;
    logic [1:0]    done_status;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    core_run_sequencer #(
        .ADDRESS_BITS  (AB),
        .CYCLE_BITS    (CB),
        .RESET_CYCLES  (R),
        .START_CYCLES  (S),
        .REPORT_CYCLES (REP)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .host_req_valid    (host_req_valid),
        .host_req_ready    (host_req_ready),
        .host_prog_address (host_prog_address),
        .host_cycle_budget (host_cycle_budget),
        .host_abort        (host_abort),
        .core_halted       (core_halted),
        .core_reset        (core_reset),
        .core_start        (core_start),
        .core_prog_address (core_prog_address),
        .core_report       (core_report),
        .done_valid        (done_valid),
        .done_ready        (done_ready),
        .done_cycles       (done_cycles),
        .done_status       (done_status)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " req_ready"}, 64'(host_req_ready), 64'(1));
        check({tag, " core_reset"}, 64'(core_reset), 64'(1));
        check({tag, " core_start"}, 64'(core_start), 64'(0));
        check({tag, " core_report"}, 64'(core_report), 64'(0));
        check({tag, " prog_addr"}, 64'(core_prog_address), 64'(0));
        check({tag, " done_valid"}, 64'(done_valid), 64'(0));
        check({tag, " done_cycles"}, 64'(done_cycles), 64'(0));
        check({tag, " done_status"}, 64'(done_status), 64'(0));
    endtask

    // One complete run, starting at a negedge with the sequencer idle.
    // halt_k: RUN cycle (1-based) with core_halted, 0 = none.
    // abort_t: cycle after acceptance (1-based) with an abort pulse, 0 = none.
    // dly: cycles done_ready is held low in DONE. rst_k: RUN cycle with reset, 0 = none.
    task automatic run_one(input logic [AB-1:0] addr, input int budget, input int halt_k,
                           input int abort_t, input int dly, input int rst_k);
        int         l;
        int         rs;
        int         dstart;
        int         th;
        int         k;
        int         exp_cycles;
        logic [1:0] exp_status;

        // Reference: compute the whole schedule from the rules.
        exp_cycles = 0;
        exp_status = ST_ABORT;
        if (rst_k > 0) begin
            rs = 1000000;
        end else if (abort_t >= 1 && abort_t <= R + S) begin
            rs = abort_t + 1;
        end else begin
            l = 1000000;
            if (halt_k > 0) l = halt_k;
            if (budget > 0 && budget < l) l = budget;
            if (abort_t > 0 && abort_t - R - S < l) l = abort_t - R - S;
            exp_cycles = l;
            if (halt_k == l) exp_status = ST_HALT;
            else if (budget == l) exp_status = ST_TIMEOUT;
            else exp_status = ST_ABORT;
            rs = R + S + l + 1;
        end
        dstart = rs + REP;
        th     = dstart + dly;

        check("idle req_ready", 64'(host_req_ready), 64'(1));
        host_req_valid    = 1'b1;
        host_prog_address = addr;
        host_cycle_budget = CB'(budget);
        host_abort        = 1'($urandom_range(0, 1));
        core_halted       = 1'($urandom_range(0, 1));
        done_ready        = 1'($urandom_range(0, 1));
        @(negedge clock);

        for (int t = 1; t <= th + 1; t++) begin
            if (t == th + 1) begin
                check("post req_ready", 64'(host_req_ready), 64'(1));
                check("post core_reset", 64'(core_reset), 64'(1));
                check("post done_valid", 64'(done_valid), 64'(0));
                check("post prog_addr", 64'(core_prog_address), 64'(addr));
                host_req_valid = 1'b0;
                host_abort     = 1'b0;
                core_halted    = 1'b0;
                done_ready     = 1'b0;
                break;
            end
            check("core_reset", 64'(core_reset), 64'((t <= R) && (t < rs)));
            check("core_start", 64'(core_start), 64'((t > R) && (t <= R + S) && (t < rs)));
            check("core_report", 64'(core_report), 64'((t >= rs) && (t < dstart)));
            check("done_valid", 64'(done_valid), 64'(t >= dstart));
            check("req_ready", 64'(host_req_ready), 64'(0));
            check("prog_addr", 64'(core_prog_address), 64'(addr));
            if (t >= dstart) begin
                check("done_cycles", 64'(done_cycles), 64'(exp_cycles));
                check("done_status", 64'(done_status), 64'(exp_status));
            end

            // Inputs for cycle t; ignored inputs are randomized.
            k                 = t - R - S;
            host_req_valid    = (t >= dstart) ? 1'b1 : 1'($urandom_range(0, 1));
            host_prog_address = AB'($urandom);
            host_cycle_budget = $urandom;
            if (t > R + S && t < rs) core_halted = (k == halt_k);
            else core_halted = 1'($urandom_range(0, 1));
            if (t < rs) host_abort = (t == abort_t);
            else host_abort = 1'($urandom_range(0, 1));
            if (t >= dstart) done_ready = (t >= th);
            else done_ready = 1'($urandom_range(0, 1));

            if (rst_k > 0 && k == rst_k) begin
                reset = 1'b0;
                @(negedge clock);
                check_reset_vals("midrun");
                reset          = 1'b1;
                host_req_valid = 1'b0;
                host_abort     = 1'b0;
                core_halted    = 1'b0;
                done_ready     = 1'b0;
                return;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int b;
        int h;
        int a;
        reset             = 1'b0;
        host_req_valid    = 1'b0;
        host_prog_address = '0;
        host_cycle_budget = '0;
        host_abort        = 1'b0;
        core_halted       = 1'b0;
        done_ready        = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b1;
        @(negedge clock);

        run_one(20'h00100, 0, 10, 0, 0, 0);       // halt in RUN cycle 10
        run_one(20'h00100, 7, 0, 0, 1, 0);        // timeout
        run_one(20'h0abcd, 7, 7, 0, 0, 0);        // halt and timeout together
        run_one(20'h12345, 0, 0, R + 2, 0, 0);    // abort in START
        run_one(20'h12345, 0, 0, R + S + 3, 0, 0); // abort in RUN cycle 3
        run_one(20'hfffff, 0, 5, 0, 3, 0);        // done_ready held low
        run_one(20'h55555, 0, 0, 0, 0, 5);        // reset in RUN cycle 5
        run_one(20'h00200, 0, 4, 0, 0, 0);        // normal run after reset

        for (int i = 0; i < 40; i++) begin
            b = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
            h = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
            a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, R + S + 20)) : 0;
            if (b == 0 && h == 0 && a == 0) h = 12;
            run_one(AB'($urandom), b, h, a, int'($urandom_range(0, 3)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_run_sequencer.md
# core_run_sequencer

Run controller for a single `RISC_V_Core` instance. It accepts a run request from a host: a program address and a cycle budget. It then sequences the core's `reset`, `start`, `prog_address` and `report` inputs through a fixed reset/start/run/report schedule. It returns a completion record to the host: cycles run and termination status. It replaces hand-timed stimulus around the core and sits between a host/debug port and the core's control inputs.

## Interface
Parameters:
- `ADDRESS_BITS`, 20: width of program address.
- `CYCLE_BITS`, 32: width of budget and cycle count.
- `RESET_CYCLES`, 4: cycles `core_reset` is held high per run (≥1).
- `START_CYCLES`, 5: cycles `core_start` is held high per run (≥1).
- `REPORT_CYCLES`, 1: cycles `core_report` is held high per run (≥1).

Ports:
- `clock`, in, 1: sole clock. One clock; reset is synchronous and active-low.
- `reset`, in, 1: synchronous, active-low.
- `host_req_valid`, in, 1: run request valid.
- `host_req_ready`, out, 1: sequencer can accept a request.
- `host_prog_address`, in, ADDRESS_BITS: program start address.
- `host_cycle_budget`, in, CYCLE_BITS: maximum RUN cycles; 0 means unlimited.
- `host_abort`, in, 1: level, terminate current run.
- `core_halted`, in, 1: core signals program end.
- `core_reset`, out, 1: to core `reset` (core polarity, active-high).
- `core_start`, out, 1: to core `start`.
- `core_prog_address`, out, ADDRESS_BITS: to core `prog_address`.
- `core_report`, out, 1: to core `report`.
- `done_valid`, out, 1: completion record valid.
- `done_ready`, in, 1: host accepts record.
- `done_cycles`, out, CYCLE_BITS: RUN cycles counted.
- `done_status`, out, 2: 0 HALT, 1 TIMEOUT, 2 ABORT, 3 unused.

## Operation
- FSM states: IDLE → RESET_HOLD → START → RUN → REPORT → DONE → IDLE.
- **IDLE**
  - `host_req_ready`=1 and `core_reset`=1.
  - On `host_req_valid & host_req_ready`: latch address and budget, clear counters, go to RESET_HOLD.
- **RESET_HOLD**: `core_reset`=1 for exactly RESET_CYCLES cycles, then START.
- **START**: `core_reset`=0 and `core_start`=1 for exactly START_CYCLES cycles, then RUN.
- **RUN**
  - Each cycle, increment `done_cycles`; it saturates at all-ones.
  - Leave RUN with the first applicable condition in this priority order:
    - `core_halted` → status HALT.
    - Budget≠0 and the count after this cycle's increment equals the budget → TIMEOUT.
    - `host_abort` → ABORT.
  - Go to REPORT.
- **REPORT**: `core_report`=1 for REPORT_CYCLES cycles, then DONE.
- **DONE**
  - `done_valid`=1; `done_cycles` and `done_status` are held stable.
  - On `done_valid & done_ready`, go to IDLE.
- Abort:
  - `host_abort` in RESET_HOLD or START goes directly to REPORT with status ABORT and `done_cycles`=0.
  - Abort is ignored in IDLE, REPORT and DONE.
- `core_prog_address` is updated only on request acceptance and is held until the next acceptance.
- `core_halted` is ignored outside RUN.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational input→output paths except `host_req_ready`, which is a decode of state only.
- Reset values: state IDLE, `host_req_ready`=1, `core_reset`=1, `core_start`=0, `core_report`=0, `core_prog_address`=0, `done_valid`=0, `done_cycles`=0, `done_status`=0.
- Request accepted at edge N:
  - `core_reset`=1 through cycles N+1..N+RESET_CYCLES.
  - `core_start`=1 for the next START_CYCLES cycles.
  - The first RUN cycle follows immediately.
- Halt sampled in RUN cycle k (1-based) → `done_cycles`=k. REPORT follows on the next cycle, and `done_valid` rises REPORT_CYCLES cycles after that.
- Halt and budget expiry in the same cycle → HALT.
- `host_req_valid` outside IDLE is not accepted. There is no queuing.
- `reset` asserted mid-run → all reset values on the next edge. The core is therefore put back into reset immediately, because `core_reset`=1.

## Structure
- Shared package `core_seq_pkg` holds:
  - the FSM state enum;
  - status codes STATUS_HALT/TIMEOUT/ABORT;
  - the status width constant.
- Sub-module `seq_phase_timer`: loadable down-counter for the RESET_HOLD/START/REPORT phase durations, with a `zero` flag. The RUN counter stays inline.

## Test plan
- Default params, addr 0x00100, budget 0, `core_halted` pulsed in RUN cycle 10:
  - `core_reset` high for 4 cycles, then `core_start` high for 5 cycles;
  - `done_cycles`=10, status HALT;
  - `core_prog_address`=0x00100 throughout.
- Budget 7, no halt → `done_cycles`=7, status TIMEOUT, `core_report` high for 1 cycle before `done_valid`.
- Budget 7 with halt in RUN cycle 7 → status HALT, `done_cycles`=7.
- Abort during START → status ABORT, `done_cycles`=0. Abort in RUN cycle 3 → ABORT, `done_cycles`=3.
- `done_ready` low for 3 cycles in DONE:
  - record held stable, `host_req_ready`=0;
  - a second request is only accepted after the handshake.
- `reset` low during RUN cycle 5 → next cycle all outputs at reset values and state IDLE. A new run then completes normally.
